// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port line-memory arbiter.
// Included first so the interface and the arbiter agree on widths and state encoding.
package mem_arb_pkg;

   localparam int MEM_ARB_DATA_W  = 256;
   localparam int MEM_ARB_ADDR_W  = 32;
   localparam int MEM_ARB_TIMEOUT = 64;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   typedef logic port_id_t;

   // Round-robin choice: a tie goes to the port that did not win last time.
   function automatic port_id_t rr_pick(input logic req0, input logic req1,
                                        input port_id_t last);
      if (req0 && req1) return ~last;
      else if (req1)    return 1'b1;
      else              return 1'b0;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both client ports and the shared memory port of mem_arbiter.
// Handshake: a client holds pN_enable_i high until the single-cycle pN_ack_o; memory pulses mem_ack_i once per mem_enable_o transaction.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int DATA_W = MEM_ARB_DATA_W,
   parameter int ADDR_W = MEM_ARB_ADDR_W
);
   logic              p0_enable_i;
   logic              p0_write_i;
   logic [ADDR_W-1:0] p0_addr_i;
   logic [DATA_W-1:0] p0_data_i;
   logic [DATA_W-1:0] p0_data_o;
   logic              p0_ack_o;

   logic              p1_enable_i;
   logic              p1_write_i;
   logic [ADDR_W-1:0] p1_addr_i;
   logic [DATA_W-1:0] p1_data_i;
   logic [DATA_W-1:0] p1_data_o;
   logic              p1_ack_o;

   logic [DATA_W-1:0] mem_data_i;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_data_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_enable_o;
   logic              mem_write_o;

   logic              busy_o;
   logic              err_o;

   modport slave (
      input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
      input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
      input  mem_data_i, mem_ack_i,
      output p0_data_o, p0_ack_o, p1_data_o, p1_ack_o,
      output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
      output busy_o, err_o
   );

   modport master (
      output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
      output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
      output mem_data_i, mem_ack_i,
      input  p0_data_o, p0_ack_o, p1_data_o, p1_ack_o,
      input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
      input  busy_o, err_o
   );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between two caches.
// The winner's request is latched for the whole transaction; a watchdog aborts if memory never acks.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W  = MEM_ARB_DATA_W,
   parameter int ADDR_W  = MEM_ARB_ADDR_W,
   parameter int TIMEOUT = MEM_ARB_TIMEOUT
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   mem_arbiter_if.slave bus
);

   localparam int               CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_e        r_state;
   port_id_t          r_grant_id;
   port_id_t          r_last_grant;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_write;

   logic              w_any_req;
   port_id_t          w_pick;
   logic              w_busy;
   logic              w_expire;
   logic              w_done;

   assign w_any_req = bus.p0_enable_i | bus.p1_enable_i;
   assign w_pick    = rr_pick(bus.p0_enable_i, bus.p1_enable_i, r_last_grant);
   assign w_busy    = (r_state == BUSY);
   assign w_expire  = w_busy && (r_count == CNT_LAST);
   // A memory ack in the expiry cycle still counts as a normal completion.
   assign w_done    = w_busy && (bus.mem_ack_i || w_expire);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_grant_id   <= 1'b0;
         r_last_grant <= 1'b1;
         r_count      <= '0;
         r_addr       <= '0;
         r_data       <= '0;
         r_write      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_state      <= BUSY;
                  r_grant_id   <= w_pick;
                  r_last_grant <= w_pick;
                  r_count      <= '0;
                  r_addr       <= w_pick ? bus.p1_addr_i  : bus.p0_addr_i;
                  r_data       <= w_pick ? bus.p1_data_i  : bus.p0_data_i;
                  r_write      <= w_pick ? bus.p1_write_i : bus.p0_write_i;
               end
            end
            BUSY: begin
               if (w_done) r_state <= IDLE;
               else        r_count <= r_count + 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.mem_enable_o = w_busy;
   assign bus.mem_addr_o   = r_addr;
   assign bus.mem_data_o   = r_data;
   assign bus.mem_write_o  = r_write;
   assign bus.busy_o       = w_busy;
   assign bus.err_o        = w_expire && !bus.mem_ack_i;

   assign bus.p0_ack_o     = w_done && (r_grant_id == 1'b0);
   assign bus.p1_ack_o     = w_done && (r_grant_id == 1'b1);
   assign bus.p0_data_o    = bus.mem_data_i;
   assign bus.p1_data_o    = bus.mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-programmable memory responder, a scoreboard of expected
// client completions, and a second instance with a short watchdog for the abort cases.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int DW    = 256;
   localparam int AW    = 32;
   localparam int EXP_W = 2 + AW + DW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wd_rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) wd ();

   mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(64)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(8)) dut_wd (
      .clk_i (clk),
      .rst_ni(wd_rst_n),
      .bus   (wd)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: {port, write, addr, data} per expected client completion.
   logic [EXP_W-1:0] exp_q[$];
   bit               m_last = 1'b1;

   task automatic push_exp(input bit port, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
      exp_q.push_back({port, wr, addr, data});
   endtask

   // Memory responder: acks in the mem_lat-th cycle of each enable run.
   int           mem_lat = 10;
   int           busy_cnt = 0;
   logic [DW-1:0] fill = '0;

   initial begin
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_enable_o) busy_cnt++;
         else                  busy_cnt = 0;
         bus.mem_ack_i  = bus.mem_enable_o && (busy_cnt == mem_lat);
         bus.mem_data_i = bus.mem_ack_i ? fill : '0;
      end
   end

   // Monitor: run lengths of mem_enable_o and scoreboard compare on every client ack.
   int ack_cnt = 0;
   int en_run = 0, last_run = 0, gap = 0, last_gap = 0;

   initial begin
      logic [EXP_W-1:0] e;
      logic [AW-1:0]    e_addr;
      logic [DW-1:0]    e_data;
      bit               e_port, e_wr;
      forever begin
         @(negedge clk);
         if (bus.mem_enable_o) begin
            if (en_run == 0) last_gap = gap;
            en_run++;
            gap = 0;
         end else begin
            if (en_run != 0) last_run = en_run;
            en_run = 0;
            gap++;
         end
         if (bus.p0_ack_o || bus.p1_ack_o) begin
            ack_cnt++;
            check("ack_pending", exp_q.size() != 0, 1'b1);
            check("ack_err", bus.err_o, 1'b0);
            if (exp_q.size() != 0) begin
               e      = exp_q.pop_front();
               e_port = e[EXP_W-1];
               e_wr   = e[EXP_W-2];
               e_addr = e[DW+AW-1:DW];
               e_data = e[DW-1:0];
               check("ack_port", {bus.p1_ack_o, bus.p0_ack_o}, e_port ? 2'b10 : 2'b01);
               check("ack_addr", bus.mem_addr_o, e_addr);
               check("ack_write", bus.mem_write_o, e_wr);
               if (e_wr) check("ack_wdata", bus.mem_data_o, e_data);
               else      check("ack_rdata", e_port ? bus.p1_data_o : bus.p0_data_o, e_data);
            end
         end
      end
   end

   task automatic wait_ack_drop(input bit port, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = port ? bus.p1_ack_o : bus.p0_ack_o;
      end
      check(port ? "ack_wait_p1" : "ack_wait_p0", seen, 1'b1);
      @(posedge clk);
      #1;
      if (port) bus.p1_enable_i = 1'b0;
      else      bus.p0_enable_i = 1'b0;
   endtask

   task automatic wait_busy(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = bus.busy_o;
      end
      check("busy_wait", seen, 1'b1);
   endtask

   initial begin
      int            base;
      int            k;
      bit            p;
      logic [DW-1:0] wdata;

      bus.p0_enable_i = 0; bus.p0_write_i = 0; bus.p0_addr_i = '0; bus.p0_data_i = '0;
      bus.p1_enable_i = 0; bus.p1_write_i = 0; bus.p1_addr_i = '0; bus.p1_data_i = '0;
      wd.p0_enable_i  = 0; wd.p0_write_i  = 0; wd.p0_addr_i  = '0; wd.p0_data_i  = '0;
      wd.p1_enable_i  = 0; wd.p1_write_i  = 0; wd.p1_addr_i  = '0; wd.p1_data_i  = '0;
      wd.mem_ack_i = 0; wd.mem_data_i = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_enable", bus.mem_enable_o, 1'b0);
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_err", bus.err_o, 1'b0);
      check("rst_acks", {bus.p1_ack_o, bus.p0_ack_o}, 2'b00);
      check("rst_write", bus.mem_write_o, 1'b0);
      check("rst_addr", bus.mem_addr_o, '0);
      check("rst_data", bus.mem_data_o, '0);
      check("rst_wd_busy", wd.busy_o, 1'b0);
      rst_n = 1'b1;
      wd_rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single p1 read, memory acks in the 10th busy cycle.
      fill = {32{8'hA5}};
      mem_lat = 10;
      base = ack_cnt;
      bus.p1_addr_i = 32'h0000_0400;
      push_exp(1'b1, 1'b0, 32'h0000_0400, {32{8'hA5}});
      m_last = 1'b1;
      bus.p1_enable_i = 1'b1;
      wait_ack_drop(1'b1, 40);
      repeat (2) @(negedge clk);
      check("t1_enable_len", last_run, 10);
      check("t1_ack_count", ack_cnt - base, 1);

      // Simultaneous requests: p0 first, then p1 after one idle cycle.
      fill = {8{32'h1234_5678}};
      mem_lat = 3;
      base = ack_cnt;
      bus.p0_addr_i = 32'h0000_0100;
      bus.p1_addr_i = 32'h0000_0200;
      push_exp(1'b0, 1'b0, 32'h0000_0100, {8{32'h1234_5678}});
      push_exp(1'b1, 1'b0, 32'h0000_0200, {8{32'h1234_5678}});
      m_last = 1'b1;
      @(posedge clk);
      #1;
      bus.p0_enable_i = 1'b1;
      bus.p1_enable_i = 1'b1;
      wait_ack_drop(1'b0, 20);
      wait_ack_drop(1'b1, 20);
      check("t2_gap", last_gap, 1);
      check("t2_ack_count", ack_cnt - base, 2);

      // Continuous contention: strict alternation from the round-robin model.
      fill = {8{32'h3C3C_0F0F}};
      mem_lat = 4;
      base = ack_cnt;
      for (int i = 0; i < 6; i++) begin
         p = ~m_last;
         m_last = p;
         push_exp(p, 1'b0, p ? 32'h0000_0200 : 32'h0000_0100, {8{32'h3C3C_0F0F}});
      end
      @(posedge clk);
      #1;
      bus.p0_enable_i = 1'b1;
      bus.p1_enable_i = 1'b1;
      for (int i = 0; i < 100 && (ack_cnt - base) < 6; i++) begin
         @(negedge clk);
         #1;
      end
      check("t3_ack_count", ack_cnt - base, 6);
      @(posedge clk);
      #1;
      bus.p0_enable_i = 1'b0;
      bus.p1_enable_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // p1 write whose inputs change after the grant; latched values must hold.
      mem_lat = 6;
      wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.p1_addr_i  = 32'h0000_0800;
      bus.p1_data_i  = wdata;
      bus.p1_write_i = 1'b1;
      push_exp(1'b1, 1'b1, 32'h0000_0800, wdata);
      m_last = 1'b1;
      bus.p1_enable_i = 1'b1;
      wait_busy(10);
      @(posedge clk);
      #1;
      bus.p1_addr_i = 32'hDEAD_0000 | 32'($urandom_range(1, 255));
      bus.p1_data_i = ~wdata;
      @(negedge clk);
      check("t4_hold_addr", bus.mem_addr_o, 32'h0000_0800);
      check("t4_hold_data", bus.mem_data_o, wdata);
      wait_ack_drop(1'b1, 20);
      bus.p1_write_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Watchdog (TIMEOUT 8): abort in the 8th busy cycle with the client ack.
      wd.p0_addr_i = 32'h0000_0040;
      wd.p0_enable_i = 1'b1;
      k = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wd.busy_o) k++;
         if (wd.err_o) break;
      end
      check("wd_err_cycle", k, 8);
      check("wd_err", wd.err_o, 1'b1);
      check("wd_ack_p0", wd.p0_ack_o, 1'b1);
      check("wd_ack_p1", wd.p1_ack_o, 1'b0);
      @(posedge clk);
      #1;
      wd.p0_enable_i = 1'b0;
      @(negedge clk);
      check("wd_idle_after", wd.busy_o, 1'b0);
      check("wd_err_pulse", wd.err_o, 1'b0);

      // Memory ack in the expiry cycle wins over the abort.
      wd.p1_enable_i = 1'b1;
      k = 0;
      for (int i = 0; i < 20 && k < 7; i++) begin
         @(negedge clk);
         if (wd.busy_o) k++;
      end
      check("wd2_reach7", k, 7);
      @(posedge clk);
      #1;
      wd.mem_ack_i = 1'b1;
      @(negedge clk);
      check("wd2_err", wd.err_o, 1'b0);
      check("wd2_ack_p1", wd.p1_ack_o, 1'b1);
      check("wd2_ack_p0", wd.p0_ack_o, 1'b0);
      @(posedge clk);
      #1;
      wd.mem_ack_i = 1'b0;
      wd.p1_enable_i = 1'b0;

      // Asynchronous reset in mid transaction.
      mem_lat = 40;
      bus.p1_addr_i = 32'h0000_0300;
      bus.p1_enable_i = 1'b1;
      wait_busy(10);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_enable", bus.mem_enable_o, 1'b0);
      check("arst_busy", bus.busy_o, 1'b0);
      check("arst_addr", bus.mem_addr_o, '0);
      bus.p1_enable_i = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      mem_lat = 5;
      fill = {8{32'h0BAD_F00D}};
      bus.p0_addr_i = 32'h0000_0100;
      bus.p1_addr_i = 32'h0000_0200;
      push_exp(1'b0, 1'b0, 32'h0000_0100, {8{32'h0BAD_F00D}});
      push_exp(1'b1, 1'b0, 32'h0000_0200, {8{32'h0BAD_F00D}});
      bus.p0_enable_i = 1'b1;
      bus.p1_enable_i = 1'b1;
      wait_ack_drop(1'b0, 20);
      wait_ack_drop(1'b1, 20);
      repeat (3) @(negedge clk);
      check("sb_drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
